// File: rtl/irq_pending_latch_if.sv
// Bus between the interrupt pending latch and the servicing logic.
// The slave modport is the latch; the master modport is the servicing side,
// which drives the raw request lines, the mask port and the ack/eoi handshake.
interface irq_pending_latch_if;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_din;
  logic       d0;
  logic       d1;
  logic       d2;
  logic       d3;
  logic       d4;
  logic       d5;
  logic       d6;
  logic       d7;
  logic       irq_req;
  logic       ack_valid;
  logic [2:0] ack_code;
  logic       eoi;
  logic       busy;
  logic [2:0] isr_idx;
  logic [7:0] pend_q;
  logic       ack_err;

  modport slave (
    input  irq_in, mask_we, mask_din, ack_valid, ack_code, eoi,
    output d0, d1, d2, d3, d4, d5, d6, d7, irq_req, busy, isr_idx, pend_q, ack_err
  );

  modport master (
    output irq_in, mask_we, mask_din, ack_valid, ack_code, eoi,
    input  d0, d1, d2, d3, d4, d5, d6, d7, irq_req, busy, isr_idx, pend_q, ack_err
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Interrupt pending latch feeding an 8-input priority encoder.
// Rising edges on irq_in set sticky pending bits; a per-line mask hides lines
// from the encoder without stopping them from latching. A three-state FSM
// (IDLE / PENDING / SERVICE) runs the request / acknowledge / end-of-interrupt
// handshake.
// Optional macro IRQ_SYNC_EN: adds a 2-flop synchronizer on irq_in (reset to
// 8'hFF) ahead of edge detection; input-to-d latency becomes 3 cycles.
module irq_pending_latch #(
  parameter logic [7:0] MASK_RST = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  irq_pending_latch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [7:0] mask_q;
  logic [7:0] mask_d;
  logic [7:0] prev_q;
  logic [2:0] isr_idx_q;
  logic       ack_err_q;

  logic [7:0] src_s;
  logic [7:0] rise_s;
  logic [7:0] elig_s;
  logic [7:0] elig_d;
  logic [7:0] clr_s;
  logic       ack_seen_s;
  logic       ack_ok_s;
  logic       ack_bad_s;
  logic [7:0] d_vec_s;

`ifdef IRQ_SYNC_EN
  logic [7:0] sync1_q;
  logic [7:0] sync2_q;

  // Two-flop synchronizer; resets high so lines held high never look like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 8'hFF;
      sync2_q <= 8'hFF;
    end else begin
      sync1_q <= bus.irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = bus.irq_in;
`endif

  // Edge detect, ack qualification against the current (old) mask, next pending/mask.
  always_comb begin
    rise_s     = src_s & ~prev_q;
    elig_s     = pending_q & ~mask_q;
    ack_seen_s = (state_q == ST_PENDING) && bus.ack_valid;
    ack_ok_s   = ack_seen_s && elig_s[bus.ack_code];
    ack_bad_s  = ack_seen_s && !elig_s[bus.ack_code];
    clr_s      = 8'h00;
    if (ack_ok_s) begin
      clr_s[bus.ack_code] = 1'b1;
    end else begin
      clr_s = 8'h00;
    end
    // A new edge wins over a same-cycle clear so the event is not lost.
    pending_d = (pending_q & ~clr_s) | rise_s;
    if (bus.mask_we) begin
      mask_d = bus.mask_din;
    end else begin
      mask_d = mask_q;
    end
    elig_d = pending_d & ~mask_d;
  end

  // Datapath registers: pending bits, mask and the edge-detect history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 8'h00;
      mask_q    <= MASK_RST;
      prev_q    <= 8'hFF;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      prev_q    <= src_s;
    end
  end

  // Handshake FSM with registered in-service index and ack error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      isr_idx_q <= 3'd0;
      ack_err_q <= 1'b0;
    end else begin
      ack_err_q <= ack_bad_s;
      case (state_q)
        ST_IDLE: begin
          if (elig_d != 8'h00) begin
            state_q <= ST_PENDING;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PENDING: begin
          if (ack_ok_s) begin
            isr_idx_q <= bus.ack_code;
            state_q   <= ST_SERVICE;
          end else if (ack_bad_s) begin
            // A rejected acknowledge leaves the state untouched.
            state_q <= ST_PENDING;
          end else if (elig_d == 8'h00) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_PENDING;
          end
        end
        ST_SERVICE: begin
          if (bus.eoi) begin
            if (elig_d != 8'h00) begin
              state_q <= ST_PENDING;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            state_q <= ST_SERVICE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Encoder inputs are blanked while a request is in service.
  always_comb begin
    if (state_q == ST_SERVICE) begin
      d_vec_s = 8'h00;
    end else begin
      d_vec_s = elig_s;
    end
  end

  assign bus.d0      = d_vec_s[0];
  assign bus.d1      = d_vec_s[1];
  assign bus.d2      = d_vec_s[2];
  assign bus.d3      = d_vec_s[3];
  assign bus.d4      = d_vec_s[4];
  assign bus.d5      = d_vec_s[5];
  assign bus.d6      = d_vec_s[6];
  assign bus.d7      = d_vec_s[7];
  assign bus.irq_req = (state_q == ST_PENDING);
  assign bus.busy    = (state_q == ST_SERVICE);
  assign bus.isr_idx = isr_idx_q;
  assign bus.pend_q  = pending_q;
  assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Scoreboard bench for irq_pending_latch: stimulus pushes the reference model's
// expected outputs into a queue; a monitor pops and compares once per cycle.
module tb_irq_pending_latch;

  localparam logic [7:0] MASK_RST = 8'h00;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  irq_pending_latch_if bus_if ();

  irq_pending_latch #(.MASK_RST(MASK_RST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] d;
    logic       irq_req;
    logic       busy;
    logic [2:0] isr_idx;
    logic [7:0] pend;
    logic       ack_err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: sticky pending set, mask, in-service flag, request flag.
  logic [7:0] m_pend;
  logic [7:0] m_mask;
  logic [7:0] m_prev;
  logic [7:0] m_s1;
  logic [7:0] m_s2;
  logic       m_svc;
  logic       m_req;
  logic [2:0] m_idx;
  logic       m_err;

  task automatic model_update(input logic r, input logic [7:0] in, input logic mwe,
                              input logic [7:0] mdin, input logic av,
                              input logic [2:0] code, input logic e);
    logic [7:0] src;
    logic [7:0] rise;
    logic [7:0] elig;
    logic [7:0] nelig;
    logic       accept;
    if (!r) begin
      m_pend = 8'h00; m_mask = MASK_RST; m_prev = 8'hFF;
      m_s1 = 8'hFF; m_s2 = 8'hFF;
      m_svc = 1'b0; m_req = 1'b0; m_idx = 3'd0; m_err = 1'b0;
    end else begin
`ifdef IRQ_SYNC_EN
      src  = m_s2;
      m_s2 = m_s1;
      m_s1 = in;
`else
      src  = in;
`endif
      rise   = src & ~m_prev;
      m_prev = src;
      elig   = m_pend & ~m_mask;
      accept = 1'b0;
      m_err  = 1'b0;
      if (m_req && !m_svc && av) begin
        if (elig[code]) accept = 1'b1;
        else m_err = 1'b1;
      end
      if (accept) m_pend[code] = 1'b0;
      m_pend = m_pend | rise;
      if (mwe) m_mask = mdin;
      nelig = m_pend & ~m_mask;
      if (m_svc) begin
        if (e) begin
          m_svc = 1'b0;
          m_req = (nelig != 8'h00);
        end
      end else if (accept) begin
        m_svc = 1'b1;
        m_req = 1'b0;
        m_idx = code;
      end else if (!m_err) begin
        m_req = (nelig != 8'h00);
      end
    end
  endtask

  // Apply one cycle of stimulus and record what the model expects afterwards.
  task automatic step(input logic r, input logic [7:0] in, input logic mwe,
                      input logic [7:0] mdin, input logic av,
                      input logic [2:0] code, input logic e);
    exp_t x;
    @(negedge clk);
    rst_n            = r;
    bus_if.irq_in    = in;
    bus_if.mask_we   = mwe;
    bus_if.mask_din  = mdin;
    bus_if.ack_valid = av;
    bus_if.ack_code  = code;
    bus_if.eoi       = e;
    model_update(r, in, mwe, mdin, av, code, e);
    x.d       = m_svc ? 8'h00 : (m_pend & ~m_mask);
    x.irq_req = m_req;
    x.busy    = m_svc;
    x.isr_idx = m_idx;
    x.pend    = m_pend;
    x.ack_err = m_err;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, req);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge.
  initial begin
    exp_t e;
    logic [7:0] dv;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        dv = {bus_if.d7, bus_if.d6, bus_if.d5, bus_if.d4,
              bus_if.d3, bus_if.d2, bus_if.d1, bus_if.d0};
        chk("d",       dv,                     e.d);
        chk("irq_req", {7'd0, bus_if.irq_req}, {7'd0, e.irq_req});
        chk("busy",    {7'd0, bus_if.busy},    {7'd0, e.busy});
        chk("isr_idx", {5'd0, bus_if.isr_idx}, {5'd0, e.isr_idx});
        chk("pend_q",  bus_if.pend_q,          e.pend);
        chk("ack_err", {7'd0, bus_if.ack_err}, {7'd0, e.ack_err});
      end
    end
  end

  function automatic logic [2:0] top_elig();
    logic [7:0] el;
    logic [2:0] r;
    el = m_pend & ~m_mask;
    r  = 3'd0;
    for (int i = 0; i < 8; i++) if (el[i]) r = i[2:0];
    return r;
  endfunction

  initial begin
    logic [7:0] in_v;
    logic [2:0] code;
    logic       av;
    logic       e;
    logic       mwe;
    logic       r;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    bus_if.irq_in = 8'h00; bus_if.mask_we = 1'b0; bus_if.mask_din = 8'h00;
    bus_if.ack_valid = 1'b0; bus_if.ack_code = 3'd0; bus_if.eoi = 1'b0;

    // Line 0 held high through reset: no edge; drop and raise gives a request.
    step(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);

    // Lines 2 and 5 rise; ack 5, then eoi returns to the remaining line 2.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h24, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h24, 1'b0, 8'h00, 1'b1, 3'd5, 1'b0);
    step(1'b1, 8'h24, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0);
    step(1'b1, 8'h24, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    step(1'b1, 8'h24, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    // Mask the only pending line, then unmask it.
    step(1'b1, 8'h24, 1'b1, 8'h04, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h24, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h24, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h24, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h24, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);

    // Line 7 pending; ack of a non-eligible code is rejected.
    step(1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h80, 1'b0, 8'h00, 1'b1, 3'd3, 1'b0);
    step(1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);

    // Line 6 re-rises in the same cycle its ack is accepted.
    step(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 3'd6, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    step(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    // All lines pending while in service, then reset.
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h7F, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    // Randomized traffic.
    in_v = 8'hFF;
    for (int n = 0; n < 3000; n++) begin
      in_v = in_v ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      av   = ($urandom_range(0, 2) == 0);
      code = ($urandom_range(0, 1) == 0) ? 3'($urandom) : top_elig();
      e    = m_svc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      mwe  = ($urandom_range(0, 29) == 0);
      r    = ($urandom_range(0, 499) != 0);
      step(r, in_v, mwe, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom), av, code, e);
    end

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    bus_if.ack_valid = 1'b0; bus_if.eoi = 1'b0; bus_if.mask_we = 1'b0;
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Interrupt front-end stage directly upstream of the 8-input priority encoder (inputs d0..d7, 3-bit code a,b,c, d7 highest priority).
- Edge-detects eight raw request lines, latches them as sticky pending bits, and applies a per-line mask.
- Presents eligible requests to the encoder on d0..d7 and consumes the encoder's code as the acknowledge index.
- Runs a request/acknowledge/end-of-interrupt handshake with the servicing logic.

Parameters:
- MASK_RST, 8'h00: reset value of the mask register. Bit i = 1 masks line i.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- irq_in  input  8  raw request lines; bit i corresponds to d_i.
- mask_we  input  1  load strobe for the mask register.
- mask_din  input  8  new mask value.
- d0..d7  output  1 each  eligible-request lines to the priority encoder.
- irq_req  output  1  high in PENDING state.
- ack_valid  input  1  acknowledge strobe, one cycle.
- ack_code  input  3  encoder output {a,b,c}; a is the MSB.
- eoi  input  1  end-of-interrupt strobe, one cycle.
- busy  output  1  high in SERVICE state.
- isr_idx  output  3  index of the request currently in service.
- pend_q  output  8  raw pending register, including masked bits.
- ack_err  output  1  one-cycle pulse on a rejected acknowledge.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - pending = 0, mask = MASK_RST, irq_prev = 8'hFF, state = IDLE, isr_idx = 0, ack_err = 0.
  - All d outputs, irq_req and busy are 0.
  - Because irq_prev resets to 8'hFF, lines already high at reset do not register an edge.
- Reset mid-operation discards all pending bits and any in-service request.
- Edge detect: rise = irq_in & ~irq_prev. irq_prev <= irq_in every cycle.
- Pending update per bit, priority highest first:
  - rise[i] sets pending[i]. Set wins over a same-cycle clear, so the new event is not lost.
  - An accepted ack for index i clears pending[i].
  - Otherwise pending[i] holds.
- Mask register:
  - mask_we loads mask_din at the clock edge.
  - Masked lines still latch pending; they are only hidden from d.
- eligible = pending & ~mask.
- Outputs d0..d7 and irq_req are combinational from registered state only; no path from irq_in.
  - State IDLE or PENDING: d_i = eligible[i].
  - State SERVICE: all d_i = 0.
  - Latency: irq_in rising ahead of clk edge k gives d_i = 1 in the cycle after edge k.
- FSM (3 states):
  - IDLE: go to PENDING when next-cycle eligible != 0.
  - PENDING: irq_req = 1.
    - ack_valid with eligible[ack_code] = 1: clear that pending bit, isr_idx <= ack_code, go to SERVICE.
    - ack_valid with eligible[ack_code] = 0: ack_err pulses 1 cycle; stay in PENDING, no state change.
    - eligible goes to 0 (e.g. via mask write): return to IDLE.
  - SERVICE: busy = 1.
    - eoi: go to PENDING if eligible != 0, else IDLE.
    - ack_valid is ignored, with no ack_err.
    - New edges keep latching.
- ack_valid in IDLE is ignored. eoi outside SERVICE is ignored.
- ack_valid and mask_we in the same cycle: the ack check uses the old mask.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: irq_in passes through a 2-flop synchronizer (reset to 8'hFF) before edge detection. Input-to-d latency becomes 3 cycles.
- Undefined: irq_in is used directly, with 1-cycle latency. Inputs must then be synchronous to clk.

Test Plan:
- Reset with irq_in = 8'h01 held, then release rst_n -> pend_q = 0, d all 0, no edge detected. Then drop irq_in[0] and raise it again -> d0 = 1 one cycle later, irq_req = 1.
- irq_in rises on 0x24 -> d2 = d5 = 1; encoder code 3'b101. ack_valid with ack_code = 5 -> pend_q = 0x04, busy = 1, isr_idx = 5, d all 0. eoi -> PENDING, d2 = 1.
- mask_din = 0x04 with pending = 0x04 in PENDING -> next cycle irq_req = 0, state IDLE, pend_q still 0x04. Unmask -> irq_req = 1.
- ack_code = 3 while eligible = 0x80 -> ack_err pulses 1 cycle, pend_q stays 0x80, state stays PENDING.
- Line 6 rises in the same cycle as the ack of index 6 -> pend_q[6] = 1 after SERVICE/eoi, d6 = 1 again.
- Assert rst_n = 0 during SERVICE with pend_q = 0xFF -> next cycle pend_q = 0, busy = 0, mask = MASK_RST.
- With IRQ_SYNC_EN defined: irq_in[7] rises -> d7 asserts 3 cycles after the first capturing edge.
